data_memory: RTL and testbench
==============================

# data_memory

Single-port data memory with memory-mapped I/O for the single-cycle 64-bit datapath, sitting in the memory stage between the ALU and the register-file writeback. It holds a small doubleword RAM, an 8-bit LED output register and an 8-bit switch input port. A 2-bit select chooses the value returned on the writeback bus.

## Interface
- DEPTH, 256: RAM depth in 64-bit doublewords; a power of two, at most 500.
- LED_ADDR, 64'h0FA0: byte address of the LED register.
- SWI_ADDR, 64'h0FA8: byte address of the switch port.
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- Direccion  input  64  byte address (ALU result).
- DataWr  input  64  store data.
- DMWr  input  1  write enable.
- DMRd  input  1  read enable.
- Swi  input  8  board switches.
- MuxSel  input  2  writeback source select.
- Salida_LeSw  output  64  writeback data.
- Led  output  8  board LEDs.

## Operation
- Address decode uses doubleword granularity; Direccion[2:0] is ignored.
- RAM region: Direccion < DEPTH*8; index = Direccion[log2(DEPTH)+2:3].
- LED_ADDR and SWI_ADDR must lie outside the RAM region.
- Any other address is unmapped: writes are ignored and reads return 0.
- Write, DMWr=1:
  - RAM: word at index <= DataWr.
  - LED_ADDR: led_reg <= DataWr[7:0].
  - SWI_ADDR or unmapped: no effect.
- Read data, combinational:
  - DMRd=0: 0.
  - RAM: stored word.
  - LED_ADDR: {56'b0, led_reg}.
  - SWI_ADDR: {56'b0, swi_q}.
  - Unmapped: 0.
- Led = led_reg.
- MuxSel:
  - 00: read data.
  - 01: Direccion (ALU passthrough).
  - 10: {56'b0, swi_q}.
  - 11: 64'b0.
- DMWr and DMRd both high: the read returns the pre-edge contents; the write commits at the edge.

## Timing
- Writes take effect on the rising clk edge; the written value is visible on the read path in the following cycle.
- The read path and Salida_LeSw are purely combinational from Direccion, DMRd, MuxSel and the current state. No read latency.
- Reset (rst_n low, asynchronous):
  - led_reg = 0, so Led = 0.
  - swi_q flops clear to 0.
  - RAM contents are not reset; they are undefined until written.
- Writes are blocked while rst_n is low. Reset asserted mid-cycle clears led_reg immediately, regardless of clk.
- Salida_LeSw during reset follows the combinational rules above with led_reg = 0.

## Configuration
- SWI_SYNC_EN defined:
  - Swi passes through a two-flop synchronizer clocked by clk and reset by rst_n.
  - swi_q is the second-stage output.
  - A switch change appears at the outputs 2 rising edges later.
- SWI_SYNC_EN undefined: swi_q = Swi, combinational with zero latency.

## Test plan
- Reset: drive rst_n=0 mid-cycle -> Led=0 immediately. With MuxSel=00, DMRd=1, Direccion=LED_ADDR -> Salida_LeSw=0.
- RAM write/read: write DataWr=64'hDEADBEEF_01234567 to Direccion=0x10; next cycle DMWr=0, DMRd=1, MuxSel=00 -> Salida_LeSw=64'hDEADBEEF_01234567. Direccion=0x13 returns the same word.
- LED map:
  - Direccion=0x0FA0, DataWr=1, DMWr=1 for one edge -> Led=8'h01.
  - Then DMWr=0, DMRd=1 -> Salida_LeSw=1.
  - Writing 64'h1FF -> Led=8'hFF.
- Switch read:
  - Swi=8'hA5, Direccion=0x0FA8, DMRd=1, MuxSel=00 -> Salida_LeSw=64'hA5 (after 2 edges when SWI_SYNC_EN is defined).
  - MuxSel=10 gives 64'hA5 for any address.
- Mux and disable:
  - MuxSel=01, Direccion=64'h1234 -> Salida_LeSw=64'h1234.
  - MuxSel=11 -> 0.
  - MuxSel=00 with DMRd=0 -> 0.
- Boundaries:
  - Write to unmapped 0x2000 or to SWI_ADDR -> no RAM or LED change; reading 0x2000 returns 0.
  - DMWr=DMRd=1 on a RAM word holding 5 while writing 9 -> read shows 5 before the edge and 9 after it.

Source files
------------

// File: rtl/data_memory.sv
// Data memory with memory-mapped LED register and switch port; optional switch synchronizer under SWI_SYNC_EN.
// Reads and writeback mux are combinational (zero latency); writes commit on rising clk; no backpressure.
module data_memory #(
    parameter int          DEPTH    = 256,
    parameter logic [63:0] LED_ADDR = 64'h0FA0,
    parameter logic [63:0] SWI_ADDR = 64'h0FA8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] Direccion,
    input  logic [63:0] DataWr,
    input  logic        DMWr,
    input  logic        DMRd,
    input  logic [7:0]  Swi,
    input  logic [1:0]  MuxSel,
    output logic [63:0] Salida_LeSw,
    output logic [7:0]  Led
);

    localparam int AW = $clog2(DEPTH);

    logic [63:0]   r_mem [DEPTH];
    logic [7:0]    r_led;
    logic [7:0]    w_swi_q;
    logic          w_in_ram;
    logic          w_is_led;
    logic          w_is_swi;
    logic [AW-1:0] w_idx;
    logic [63:0]   w_rd_dat;

    // Decode on doubleword boundaries, so the low three address bits never matter.
    assign w_in_ram = (Direccion >> (AW + 3)) == 64'd0;
    assign w_is_led = Direccion[63:3] == LED_ADDR[63:3];
    assign w_is_swi = Direccion[63:3] == SWI_ADDR[63:3];
    assign w_idx    = Direccion[AW+2:3];

    // RAM has no reset; rst_n only gates writes.
    always_ff @(posedge clk) begin
        if (rst_n && DMWr && w_in_ram) begin
            r_mem[w_idx] <= DataWr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_led <= 8'd0;
        end else if (DMWr && w_is_led) begin
            r_led <= DataWr[7:0];
        end
    end

`ifdef SWI_SYNC_EN
    logic [7:0] r_swi_meta;
    logic [7:0] r_swi_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_swi_meta <= 8'd0;
            r_swi_sync <= 8'd0;
        end else begin
            r_swi_meta <= Swi;
            r_swi_sync <= r_swi_meta;
        end
    end

    assign w_swi_q = r_swi_sync;
`else
    assign w_swi_q = Swi;
`endif

    always_comb begin
        w_rd_dat = 64'd0;
        if (DMRd) begin
            if (w_in_ram) begin
                w_rd_dat = r_mem[w_idx];
            end else if (w_is_led) begin
                w_rd_dat = {56'd0, r_led};
            end else if (w_is_swi) begin
                w_rd_dat = {56'd0, w_swi_q};
            end
        end
    end

    always_comb begin
        Salida_LeSw = 64'd0;
        case (MuxSel)
            2'b00:   Salida_LeSw = w_rd_dat;
            2'b01:   Salida_LeSw = Direccion;
            2'b10:   Salida_LeSw = {56'd0, w_swi_q};
            default: Salida_LeSw = 64'd0;
        endcase
    end

    assign Led = r_led;

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: expected values queued when stimulus is driven, popped at each check.
module tb_data_memory;

    logic        clk;
    logic        rst_n;
    logic [63:0] Direccion;
    logic [63:0] DataWr;
    logic        DMWr;
    logic        DMRd;
    logic [7:0]  Swi;
    logic [1:0]  MuxSel;
    logic [63:0] Salida_LeSw;
    logic [7:0]  Led;

    int checks   = 0;
    int failures = 0;

    logic [63:0] exp_q [$];
    logic [7:0]  led_q [$];

    data_memory dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Direccion  (Direccion),
        .DataWr     (DataWr),
        .DMWr       (DMWr),
        .DMRd       (DMRd),
        .Swi        (Swi),
        .MuxSel     (MuxSel),
        .Salida_LeSw(Salida_LeSw),
        .Led        (Led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input logic [63:0] v);
        exp_q.push_back(v);
    endtask

    task automatic expect_led(input logic [7:0] v);
        led_q.push_back(v);
    endtask

    task automatic check_out(input string tag);
        logic [63:0] e;
        #1;
        e = exp_q.pop_front();
        checks++;
        assert (Salida_LeSw === e) else begin
            failures++;
            $error("FAIL %s: Salida_LeSw=%h expected=%h", tag, Salida_LeSw, e);
        end
    endtask

    task automatic check_led(input string tag);
        logic [7:0] e;
        #1;
        e = led_q.pop_front();
        checks++;
        assert (Led === e) else begin
            failures++;
            $error("FAIL %s: Led=%h expected=%h", tag, Led, e);
        end
    endtask

    task automatic swi_settle();
`ifdef SWI_SYNC_EN
        step();
        step();
`endif
    endtask

    initial begin
        rst_n     = 1'b0;
        Direccion = 64'd0;
        DataWr    = 64'd0;
        DMWr      = 1'b0;
        DMRd      = 1'b0;
        Swi       = 8'd0;
        MuxSel    = 2'b00;
        step();
        step();
        expect_led(8'h00);
        check_led("reset_led");
        #2 rst_n = 1'b1;

        // Load LED and two RAM words before exercising mid-cycle reset.
        step();
        Direccion = 64'h0FA0; DataWr = 64'h3C; DMWr = 1'b1;
        step();
        expect_led(8'h3C);
        check_led("led_pre_reset");
        Direccion = 64'h40; DataWr = 64'hAAAA_5555_AAAA_5555;
        step();
        Direccion = 64'h0; DataWr = 64'h0123_0000_0000_0777;
        step();
        DMWr = 1'b0;

        // Asynchronous reset between edges.
        #2 rst_n = 1'b0;
        expect_led(8'h00);
        check_led("async_reset_led");
        Direccion = 64'h0FA0; DMRd = 1'b1; MuxSel = 2'b00;
        expect_out(64'd0);
        check_out("reset_led_read");
        Direccion = 64'h40; DataWr = 64'h0BAD; DMWr = 1'b1;
        step();
        DMWr = 1'b0;
        #2 rst_n = 1'b1;
        expect_out(64'hAAAA_5555_AAAA_5555);
        check_out("write_blocked_in_reset");

        // RAM write / read, low address bits ignored.
        step();
        Direccion = 64'h10; DataWr = 64'hDEADBEEF_01234567; DMWr = 1'b1; DMRd = 1'b0;
        step();
        DMWr = 1'b0; DMRd = 1'b1;
        expect_out(64'hDEADBEEF_01234567);
        check_out("ram_read");
        Direccion = 64'h13;
        expect_out(64'hDEADBEEF_01234567);
        check_out("ram_read_unaligned");

        // LED map.
        Direccion = 64'h0FA0; DataWr = 64'h1; DMWr = 1'b1; DMRd = 1'b0;
        step();
        DMWr = 1'b0; DMRd = 1'b1;
        expect_led(8'h01);
        check_led("led_write_1");
        expect_out(64'h1);
        check_out("led_read_1");
        DataWr = 64'h1FF; DMWr = 1'b1;
        step();
        DMWr = 1'b0;
        expect_led(8'hFF);
        check_led("led_write_1ff");
        expect_out(64'hFF);
        check_out("led_read_ff");

        // Switch port.
        Swi = 8'hA5;
        swi_settle();
        Direccion = 64'h0FA8; DMRd = 1'b1; MuxSel = 2'b00;
        expect_out(64'hA5);
        check_out("swi_read");
        MuxSel = 2'b10; Direccion = 64'h10;
        expect_out(64'hA5);
        check_out("mux_swi_ram_addr");
        Direccion = 64'h7777;
        expect_out(64'hA5);
        check_out("mux_swi_other_addr");

        // Mux and read disable.
        MuxSel = 2'b01; Direccion = 64'h1234;
        expect_out(64'h1234);
        check_out("mux_alu");
        MuxSel = 2'b11;
        expect_out(64'd0);
        check_out("mux_zero");
        MuxSel = 2'b00; DMRd = 1'b0; Direccion = 64'h10;
        expect_out(64'd0);
        check_out("read_disabled");

        // Unmapped and switch-address writes must not touch RAM or LED.
        Direccion = 64'h2000; DataWr = 64'hFFFF_FFFF_FFFF_FFFF; DMWr = 1'b1;
        step();
        Direccion = 64'h2010;
        step();
        Direccion = 64'h0FA8; DataWr = 64'h5A;
        step();
        DMWr = 1'b0; DMRd = 1'b1;
        expect_led(8'hFF);
        check_led("led_unchanged");
        Direccion = 64'h2000;
        expect_out(64'd0);
        check_out("unmapped_read");
        Direccion = 64'h0;
        expect_out(64'h0123_0000_0000_0777);
        check_out("ram0_unchanged");
        Direccion = 64'h10;
        expect_out(64'hDEADBEEF_01234567);
        check_out("ram10_unchanged");
        Direccion = 64'h0FA8;
        expect_out(64'hA5);
        check_out("swi_unchanged");

        // Simultaneous read and write returns pre-edge contents.
        Direccion = 64'h18; DataWr = 64'd5; DMWr = 1'b1; DMRd = 1'b0;
        step();
        DataWr = 64'd9; DMRd = 1'b1;
        expect_out(64'd5);
        check_out("rdwr_before_edge");
        step();
        expect_out(64'd9);
        check_out("rdwr_after_edge");
        DMWr = 1'b0;

        // Switch change propagates.
        Swi = 8'h3C; Direccion = 64'h0FA8;
        swi_settle();
        expect_out(64'h3C);
        check_out("swi_change");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
